l1_mem_req_arbiter: RTL and testbench
=====================================

Name: l1_mem_req_arbiter

Overview:
- Shares the single cache-to-memory request channel between the L1 requesters: port 0 icache refill, port 1 dcache refill, port 2 dcache write-through / write-buffer drain.
- Round-robin arbitration with request hold until granted.
- Tags each issued request with the requester index; routes responses back by tag.
- Throttles stores so that at most MaxOutstandingStores writes are in flight. Sits between the L1 caches and the AXI adapter.

Parameters:
NrPorts, 3, number of requesters (index 0..NrPorts-1)
AddrWidth, 64, request address width
DataWidth, 128, line/write data width (equals cache line width)
TidWidth, 2, per-requester transaction ID width
MaxOutstandingStores, 7, maximum in-flight write requests (1..15)
WritePortMask, 3'b100, bit set = port issues writes and is subject to store throttling

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NrPorts  per-port request valid
we_i  in  NrPorts  per-port write flag
addr_i  in  NrPorts*AddrWidth  per-port address
wdata_i  in  NrPorts*DataWidth  per-port write data
tid_i  in  NrPorts*TidWidth  per-port transaction ID
gnt_o  out  NrPorts  one-hot grant, one cycle per accepted request
rvalid_o  out  NrPorts  one-hot response valid
rdata_o  out  DataWidth  response data (shared, qualified by rvalid_o)
rtid_o  out  TidWidth  response transaction ID
mem_req_o  out  1  memory request valid
mem_gnt_i  in  1  memory accepts request
mem_we_o  out  1  write flag
mem_addr_o  out  AddrWidth  address
mem_wdata_o  out  DataWidth  write data
mem_tid_o  out  TidWidth+IdxW  {port index, tid}; IdxW = clog2(NrPorts)
mem_rvalid_i  in  1  response valid (reads and write acks)
mem_rwe_i  in  1  response is a write ack
mem_rtid_i  in  TidWidth+IdxW  response tag
mem_rdata_i  in  DataWidth  response data
idle_o  out  1  no request held, no store outstanding
err_o  out  1  sticky: write ack with zero outstanding, or tag index >= NrPorts

Behaviour:
- Reset: state IDLE, rr_ptr=0, store_cnt=0, err_o=0. Outputs: mem_req_o=0, gnt_o=0, rvalid_o=0, idle_o=1. Data/address outputs are 0.
- Eligibility: req_i[p] & ~(we_i[p] & WritePortMask[p] & store_cnt==MaxOutstandingStores).
- FSM IDLE: if any port is eligible, pick the first eligible port at or after rr_ptr, wrapping. Latch its index, we, addr, wdata and tid into a holding register; go to ISSUE. Nothing is driven on mem in this cycle (1-cycle latency, registered outputs).
- FSM ISSUE: mem_req_o=1 with held fields, stable until mem_gnt_i. On mem_gnt_i: gnt_o[held idx]=1 for that cycle; rr_ptr = idx+1 mod NrPorts; go to IDLE.
  - No back-to-back issue: a single-issue throughput of one request per 2 cycles is acceptable.
- Requesters keep req_i and payload stable until gnt_o. Dropping req_i while held does not cancel the held request.
- store_cnt:
  - +1 on a granted write from a WritePortMask port.
  - -1 on mem_rvalid_i & mem_rwe_i.
  - Both in the same cycle: unchanged.
  - Decrement at 0: count stays 0, err_o set.
  - Never exceeds MaxOutstandingStores, because the eligibility mask applies at selection.
- Responses are combinational pass-through, 0 cycles:
  - rvalid_o[mem_rtid_i[upper IdxW bits]] = mem_rvalid_i.
  - rdata_o = mem_rdata_i; rtid_o = mem_rtid_i lower bits.
  - An index >= NrPorts drives no rvalid_o and sets err_o.
- Responses and requests proceed independently in the same cycle.
- idle_o = (state==IDLE) & store_cnt==0.
- Reset mid-ISSUE: request dropped immediately, counter cleared. The memory side is reset together with this block.

Decomposition:
- Shared package l1_arb_pkg:
  - arb_state_e {IDLE, ISSUE}
  - mem_req_t struct {we, addr, wdata, tid}
  - IdxW function
- One sub-module rr_pick: combinational round-robin first-one-from-pointer. Inputs: eligible vector, rr_ptr. Outputs: index, valid.

Test Plan:
- Single read: port 1 req, addr 0x8000_0040, tid 2. Expect mem_req_o at cycle 1 with mem_tid_o=4'b0110. mem_gnt_i at cycle 3 gives gnt_o=3'b010 that cycle. Response tag 0x6 gives rvalid_o=3'b010, rtid_o=2.
- Round-robin: all three ports request continuously with immediate mem_gnt_i. Grant order is 0,1,2,0,1,2, with each grant 2 cycles apart.
- Store throttle: 8 writes on port 2 with no acks. The first 7 are granted, then store_cnt=7 and port 2 is blocked while ports 0/1 are still served. One ack unblocks exactly one more write.
- Simultaneous grant of a write and a write ack at store_cnt=3: count stays 3. A write ack at store_cnt=0 sets err_o and leaves the count at 0.
- Hold: mem_gnt_i withheld for 5 cycles while req_i is dropped. mem_req_o and payload stay stable across all 5 cycles; gnt_o fires once on the grant.
- Async reset asserted during ISSUE: mem_req_o=0 and idle_o=1 immediately. After release, rr_ptr=0, so port 0 wins the first contention.

Source files
------------

// File: rtl/l1_arb_pkg.sv
// Shared types and helpers for the L1 memory request arbiter.
package l1_arb_pkg;

  localparam int DefAddrWidth = 64;
  localparam int DefDataWidth = 128;
  localparam int DefTidWidth  = 2;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_e;

  // Payload captured from the winning requester while it waits for mem_gnt_i.
  typedef struct packed {
    logic                    we;
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] wdata;
    logic [DefTidWidth-1:0]  tid;
  } mem_req_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1_mem_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after rr_ptr, wrapping.
module rr_pick
  import l1_arb_pkg::*;
#(
  parameter  int NrPorts = 3,
  localparam int IdxW    = idx_w(NrPorts)
) (
  input  logic [NrPorts-1:0] eligible,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  logic            hi_valid;
  logic            lo_valid;
  logic [IdxW-1:0] hi_idx;
  logic [IdxW-1:0] lo_idx;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = NrPorts - 1; c >= 0; c--) begin
      if (eligible[c]) begin
        lo_valid = 1'b1;
        lo_idx   = IdxW'(c);
        if (c >= int'(rr_ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = IdxW'(c);
        end
      end
    end
    valid = lo_valid;
    idx   = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/l1_mem_req_arbiter.sv
// Round-robin arbiter sharing the cache-to-memory request channel between the
// L1 requesters, with tag-based response routing and store throttling.
module l1_mem_req_arbiter
  import l1_arb_pkg::*;
#(
  parameter  int                 NrPorts              = 3,
  parameter  int                 AddrWidth            = DefAddrWidth,
  parameter  int                 DataWidth            = DefDataWidth,
  parameter  int                 TidWidth             = DefTidWidth,
  parameter  int                 MaxOutstandingStores = 7,
  parameter  logic [NrPorts-1:0] WritePortMask        = NrPorts'(3'b100),
  localparam int                 IdxW                 = idx_w(NrPorts)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NrPorts-1:0]       req_i,
  input  logic [NrPorts-1:0]       we_i,
  input  logic [NrPorts*AddrWidth-1:0] addr_i,
  input  logic [NrPorts*DataWidth-1:0] wdata_i,
  input  logic [NrPorts*TidWidth-1:0]  tid_i,
  output logic [NrPorts-1:0]       gnt_o,
  output logic [NrPorts-1:0]       rvalid_o,
  output logic [DataWidth-1:0]     rdata_o,
  output logic [TidWidth-1:0]      rtid_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic                     mem_we_o,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  output logic [TidWidth+IdxW-1:0] mem_tid_o,
  input  logic                     mem_rvalid_i,
  input  logic                     mem_rwe_i,
  input  logic [TidWidth+IdxW-1:0] mem_rtid_i,
  input  logic [DataWidth-1:0]     mem_rdata_i,
  output logic                     idle_o,
  output logic                     err_o
);

  arb_state_e      state_q, state_d;
  mem_req_t        held_q;
  logic [IdxW-1:0] held_idx_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] rsp_idx;
  logic [3:0]      store_cnt_q;
  logic [NrPorts-1:0] eligible;
  logic            pick_valid;
  logic            issue_done;
  logic            store_full;
  logic            store_inc;
  logic            store_dec;
  logic            underflow;
  logic            rsp_bad;
  logic            err_q;

  // Writes from throttled ports are masked out once the store budget is spent.
  assign store_full = (store_cnt_q == 4'(MaxOutstandingStores));
  assign eligible   = req_i & ~(we_i & WritePortMask & {NrPorts{store_full}});

  rr_pick #(.NrPorts(NrPorts)) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   if (mem_gnt_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issue_done = (state_q == ISSUE) & mem_gnt_i;
  assign store_inc  = issue_done & held_q.we & WritePortMask[held_idx_q];
  assign store_dec  = mem_rvalid_i & mem_rwe_i;
  assign underflow  = store_dec & ~store_inc & (store_cnt_q == 4'd0);
  assign rsp_idx    = mem_rtid_i[TidWidth +: IdxW];
  assign rsp_bad    = mem_rvalid_i & (int'(rsp_idx) >= NrPorts);

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int p = 0; p < NrPorts; p++) begin
      gnt_o[p]    = issue_done & (held_idx_q == IdxW'(p));
      rvalid_o[p] = mem_rvalid_i & (rsp_idx == IdxW'(p));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      held_q      <= '0;
      held_idx_q  <= '0;
      rr_ptr_q    <= '0;
      store_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) begin
        held_idx_q   <= pick_idx;
        held_q.we    <= we_i[pick_idx];
        held_q.addr  <= addr_i[pick_idx*AddrWidth +: AddrWidth];
        held_q.wdata <= wdata_i[pick_idx*DataWidth +: DataWidth];
        held_q.tid   <= tid_i[pick_idx*TidWidth +: TidWidth];
      end
      if (issue_done) begin
        rr_ptr_q <= (held_idx_q == IdxW'(NrPorts - 1)) ? '0 : held_idx_q + 1'b1;
      end
      // A grant and an ack in the same cycle cancel out.
      if (store_inc && !store_dec) begin
        store_cnt_q <= store_cnt_q + 4'd1;
      end else if (store_dec && !store_inc && store_cnt_q != 4'd0) begin
        store_cnt_q <= store_cnt_q - 4'd1;
      end
      err_q <= err_q | underflow | rsp_bad;
    end
  end

  assign mem_req_o   = (state_q == ISSUE);
  assign mem_we_o    = held_q.we;
  assign mem_addr_o  = held_q.addr;
  assign mem_wdata_o = held_q.wdata;
  assign mem_tid_o   = {held_idx_q, held_q.tid};
  assign rdata_o     = mem_rdata_i;
  assign rtid_o      = mem_rtid_i[TidWidth-1:0];
  assign idle_o      = (state_q == IDLE) & (store_cnt_q == 4'd0);
  assign err_o       = err_q;

endmodule

// File: tb/tb_l1_mem_req_arbiter.sv
// Self-checking bench for l1_mem_req_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_l1_mem_req_arbiter;

  localparam int N     = 3;
  localparam int AW    = 64;
  localparam int DW    = 128;
  localparam int TW    = 2;
  localparam int IW    = 2;
  localparam int MAXST = 7;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      req_i, we_i, gnt_o, rvalid_o;
  logic [N*AW-1:0]   addr_i;
  logic [N*DW-1:0]   wdata_i;
  logic [N*TW-1:0]   tid_i;
  logic [DW-1:0]     rdata_o, mem_wdata_o, mem_rdata_i;
  logic [TW-1:0]     rtid_o;
  logic              mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_rwe_i;
  logic              idle_o, err_o;
  logic [AW-1:0]     mem_addr_o;
  logic [TW+IW-1:0]  mem_tid_o, mem_rtid_i;

  always #5 clk_i = ~clk_i;

  l1_mem_req_arbiter #(
    .NrPorts(N), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW),
    .MaxOutstandingStores(MAXST), .WritePortMask(3'b100)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .tid_i(tid_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rtid_o(rtid_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_tid_o(mem_tid_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rwe_i(mem_rwe_i), .mem_rtid_i(mem_rtid_i),
    .mem_rdata_i(mem_rdata_i), .idle_o(idle_o), .err_o(err_o)
  );

  // Requester-side and memory-side stimulus
  bit              b_req[N];
  bit              b_we[N];
  logic [AW-1:0]   b_addr[N];
  logic [DW-1:0]   b_wdata[N];
  logic [TW-1:0]   b_tid[N];
  bit              b_mem_gnt, b_rvalid, b_rwe;
  logic [3:0]      b_rtid;
  logic [DW-1:0]   b_rdata;

  // Reference model: one outstanding held transaction, pointer, store budget
  bit              m_busy;
  int              m_port, m_ptr, m_cnt;
  bit              m_we, m_err;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [TW-1:0]   m_tid;

  logic [N-1:0]    last_gnt, obs_gnt;
  int              gcnt[N];
  int              gq_port[$];
  int              gq_cyc[$];
  int              cyc;
  int              checks, failures;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic packInputs();
    req_i        = {b_req[2], b_req[1], b_req[0]};
    we_i         = {b_we[2], b_we[1], b_we[0]};
    addr_i       = {b_addr[2], b_addr[1], b_addr[0]};
    wdata_i      = {b_wdata[2], b_wdata[1], b_wdata[0]};
    tid_i        = {b_tid[2], b_tid[1], b_tid[0]};
    mem_gnt_i    = b_mem_gnt;
    mem_rvalid_i = b_rvalid;
    mem_rwe_i    = b_rwe;
    mem_rtid_i   = b_rtid;
    mem_rdata_i  = b_rdata;
  endtask

  task automatic settle();
    packInputs();
    #1;
  endtask

  task automatic compareAll();
    logic [N-1:0] eg, erv;
    int ridx;
    eg = '0;
    if (m_busy && b_mem_gnt) eg = N'(1) << m_port;
    last_gnt = eg;
    ridx = int'(b_rtid[3:2]);
    erv = (b_rvalid && ridx < N) ? N'(1) << ridx : '0;
    checkOutput("mem_req", DW'(mem_req_o), DW'(m_busy));
    checkOutput("gnt", DW'(gnt_o), DW'(eg));
    checkOutput("rvalid", DW'(rvalid_o), DW'(erv));
    checkOutput("idle", DW'(idle_o), DW'(!m_busy && m_cnt == 0));
    checkOutput("err", DW'(err_o), DW'(m_err));
    if (m_busy) begin
      checkOutput("mem_we", DW'(mem_we_o), DW'(m_we));
      checkOutput("mem_addr", DW'(mem_addr_o), DW'(m_addr));
      checkOutput("mem_wdata", mem_wdata_o, m_wdata);
      checkOutput("mem_tid", DW'(mem_tid_o), DW'({2'(m_port), m_tid}));
    end
    if (b_rvalid) begin
      checkOutput("rdata", rdata_o, b_rdata);
      checkOutput("rtid", DW'(rtid_o), DW'(b_rtid[1:0]));
    end
  endtask

  // Advance the model across one clock edge using this cycle's inputs
  task automatic modelStep();
    bit inc, dec;
    int p;
    inc = 0;
    if (m_busy) begin
      if (b_mem_gnt) begin
        inc    = m_we && (m_port == 2);
        m_ptr  = (m_port + 1) % N;
        m_busy = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!m_busy && b_req[p] && !(b_we[p] && p == 2 && m_cnt == MAXST)) begin
          m_busy  = 1;
          m_port  = p;
          m_we    = b_we[p];
          m_addr  = b_addr[p];
          m_wdata = b_wdata[p];
          m_tid   = b_tid[p];
        end
      end
    end
    dec = b_rvalid && b_rwe;
    if (inc && !dec) m_cnt++;
    else if (dec && !inc) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    if (b_rvalid && int'(b_rtid[3:2]) >= N) m_err = 1;
  endtask

  task automatic applyStimulus();
    packInputs();
    #4;
    compareAll();
    obs_gnt = gnt_o;
    modelStep();
    for (int p = 0; p < N; p++) begin
      if (obs_gnt[p]) begin
        gcnt[p]++;
        gq_port.push_back(p);
        gq_cyc.push_back(cyc);
      end
      if (last_gnt[p]) b_req[p] = 0;
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearStimulus();
    for (int p = 0; p < N; p++) begin
      b_req[p] = 0; b_we[p] = 0; b_addr[p] = '0; b_wdata[p] = '0; b_tid[p] = '0;
      gcnt[p] = 0;
    end
    b_mem_gnt = 0; b_rvalid = 0; b_rwe = 0; b_rtid = '0; b_rdata = '0;
    gq_port.delete();
    gq_cyc.delete();
    cyc = 0;
  endtask

  task automatic doReset();
    clearStimulus();
    packInputs();
    rst_ni = 1'b0;
    m_busy = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    #2;
    checkOutput("rst_mem_req", DW'(mem_req_o), DW'(0));
    checkOutput("rst_gnt", DW'(gnt_o), DW'(0));
    checkOutput("rst_rvalid", DW'(rvalid_o), DW'(0));
    checkOutput("rst_idle", DW'(idle_o), DW'(1));
    checkOutput("rst_err", DW'(err_o), DW'(0));
    checkOutput("rst_addr", DW'(mem_addr_o), DW'(0));
    checkOutput("rst_wdata", mem_wdata_o, DW'(0));
    checkOutput("rst_tid", DW'(mem_tid_o), DW'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic newRequest(input int p, input bit we);
    b_req[p]   = 1;
    b_we[p]    = we;
    b_addr[p]  = {$urandom, $urandom};
    b_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
    b_tid[p]   = TW'($urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    clearStimulus();
    packInputs();
    @(posedge clk_i);
    #1;
    doReset();

    // Single read on port 1
    b_req[1] = 1; b_addr[1] = 64'h8000_0040; b_tid[1] = 2'd2;
    applyStimulus();
    settle();
    checkOutput("single_mem_req", DW'(mem_req_o), DW'(1));
    checkOutput("single_mem_tid", DW'(mem_tid_o), DW'(4'b0110));
    checkOutput("single_addr", DW'(mem_addr_o), DW'(64'h8000_0040));
    applyStimulus();
    applyStimulus();
    b_mem_gnt = 1;
    settle();
    checkOutput("single_gnt", DW'(gnt_o), DW'(3'b010));
    applyStimulus();
    b_mem_gnt = 0;
    b_rvalid = 1; b_rtid = 4'h6; b_rdata = {$urandom, $urandom, $urandom, $urandom};
    settle();
    checkOutput("single_rvalid", DW'(rvalid_o), DW'(3'b010));
    checkOutput("single_rtid", DW'(rtid_o), DW'(2));
    applyStimulus();
    b_rvalid = 0;

    // Round-robin with continuous requests and immediate grants
    doReset();
    b_mem_gnt = 1;
    for (int i = 0; i < 14; i++) begin
      for (int p = 0; p < N; p++) if (!b_req[p]) newRequest(p, 0);
      applyStimulus();
    end
    checkOutput("rr_count", DW'(gq_port.size() >= 6), DW'(1));
    if (gq_port.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("rr_port%0d", k), DW'(gq_port[k]), DW'(k % 3));
        checkOutput($sformatf("rr_gap%0d", k), DW'(gq_cyc[k] - gq_cyc[0]), DW'(2 * k));
      end
    end

    // Store throttle on port 2 with no acks
    doReset();
    b_mem_gnt = 1;
    for (int i = 0; i < 30; i++) begin
      if (!b_req[2]) newRequest(2, 1);
      applyStimulus();
    end
    checkOutput("throttle_cap", DW'(gcnt[2]), DW'(7));
    checkOutput("throttle_busy", DW'(idle_o), DW'(0));
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 2; p++) if (!b_req[p]) newRequest(p, 0);
      applyStimulus();
    end
    checkOutput("throttle_others", DW'(gcnt[0] + gcnt[1]), DW'(5));
    checkOutput("throttle_still", DW'(gcnt[2]), DW'(7));
    b_req[0] = 0; b_req[1] = 0;
    b_rvalid = 1; b_rwe = 1; b_rtid = 4'b1000;
    applyStimulus();
    b_rvalid = 0; b_rwe = 0;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("throttle_one_more", DW'(gcnt[2]), DW'(8));

    // Write grant and write ack in the same cycle, then underflow
    doReset();
    b_mem_gnt = 1;
    for (int i = 0; i < 20; i++) begin
      if (!b_req[2] && gcnt[2] < 3) newRequest(2, 1);
      applyStimulus();
    end
    checkOutput("simul_pre", DW'(gcnt[2]), DW'(3));
    b_mem_gnt = 0;
    newRequest(2, 1);
    applyStimulus();
    b_mem_gnt = 1; b_rvalid = 1; b_rwe = 1; b_rtid = 4'b1001;
    applyStimulus();
    b_mem_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      b_rvalid = 1; b_rwe = 1; b_rtid = 4'b1000;
      applyStimulus();
      if (k == 1) checkOutput("simul_two_acks", DW'(idle_o), DW'(0));
    end
    b_rvalid = 0; b_rwe = 0;
    settle();
    checkOutput("simul_drained", DW'(idle_o), DW'(1));
    checkOutput("simul_no_err", DW'(err_o), DW'(0));
    b_rvalid = 1; b_rwe = 1; b_rtid = 4'b1000;
    applyStimulus();
    b_rvalid = 0; b_rwe = 0;
    settle();
    checkOutput("underflow_err", DW'(err_o), DW'(1));
    checkOutput("underflow_idle", DW'(idle_o), DW'(1));

    // Hold: grant withheld while the requester drops req_i
    doReset();
    newRequest(0, 0);
    b_addr[0] = 64'h1234_5678_9abc_def0;
    applyStimulus();
    b_req[0] = 0;
    b_addr[0] = 64'h0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput("hold_req", DW'(mem_req_o), DW'(1));
      checkOutput("hold_addr", DW'(mem_addr_o), DW'(64'h1234_5678_9abc_def0));
      applyStimulus();
    end
    b_mem_gnt = 1;
    settle();
    checkOutput("hold_gnt", DW'(gnt_o), DW'(3'b001));
    applyStimulus();
    b_mem_gnt = 0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("hold_once", DW'(gcnt[0]), DW'(1));

    // Asynchronous reset while a request is being issued
    doReset();
    newRequest(1, 0);
    applyStimulus();
    #1;
    doReset();
    b_mem_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < N; p++) if (!b_req[p]) newRequest(p, 0);
      applyStimulus();
    end
    checkOutput("post_rst_any", DW'(gq_port.size() > 0), DW'(1));
    if (gq_port.size() > 0) checkOutput("post_rst_first", DW'(gq_port[0]), DW'(0));

    // Response with an out-of-range port index
    for (int p = 0; p < N; p++) b_req[p] = 0;
    b_mem_gnt = 0;
    for (int i = 0; i < 2; i++) applyStimulus();
    b_rvalid = 1; b_rwe = 0; b_rtid = 4'hC;
    settle();
    checkOutput("badtag_rvalid", DW'(rvalid_o), DW'(0));
    applyStimulus();
    b_rvalid = 0;
    settle();
    checkOutput("badtag_err", DW'(err_o), DW'(1));

    // Random traffic against the reference model
    doReset();
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < N; p++) begin
        if (!b_req[p] && $urandom_range(0, 2) == 0)
          newRequest(p, (p == 2) ? ($urandom_range(0, 3) != 0) : 1'b0);
      end
      b_mem_gnt = ($urandom_range(0, 1) == 1);
      b_rvalid  = ($urandom_range(0, 2) == 0);
      b_rdata   = {$urandom, $urandom, $urandom, $urandom};
      if (b_rvalid && m_cnt > 0 && $urandom_range(0, 1) == 1) begin
        b_rwe  = 1;
        b_rtid = {2'd2, 2'($urandom_range(0, 3))};
      end else begin
        b_rwe  = 0;
        b_rtid = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      end
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
